// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core: the data word and register index.
// Imported by the integer register file and its read ports.
package hsv_core_pkg;

    typedef logic [31:0] word;
    typedef logic [4:0]  reg_addr;

    localparam reg_addr REG_ZERO = 5'd0;

endpackage

// File: rtl/hsv_core_regfile_rdport.sv
// One combinational read port of the hsv integer register file: index mux, x0 zeroing
// and, when HSV_REGFILE_BYPASS_EN is defined, same-cycle write-to-read forwarding.
module hsv_core_regfile_rdport
    import hsv_core_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][XLEN-1:0] i_regs,
    input  logic [AW-1:0]                 i_addr,
`ifdef HSV_REGFILE_BYPASS_EN
    input  logic                          i_fwdValid,
    input  logic [AW-1:0]                 i_wrAddr,
    input  logic [XLEN-1:0]               i_wrData,
`endif
    output logic [XLEN-1:0]               o_data
);

    logic w_isZero;

    assign w_isZero = (i_addr == AW'(REG_ZERO));

    // x0 is forced to zero here so the forwarding path can never leak a write to x0.
    always_comb begin
        o_data = '0;
        if (!w_isZero) begin
            o_data = i_regs[i_addr];
`ifdef HSV_REGFILE_BYPASS_EN
            if (i_fwdValid && (i_addr == i_wrAddr)) begin
                o_data = i_wrData;
            end
`endif
        end
    end

endmodule

// File: rtl/hsv_core_regfile.sv
// Integer register file x0..x31 for the hsv core: two combinational reads, one synchronous write.
// Build option: define HSV_REGFILE_BYPASS_EN to forward the in-flight write to the read ports.
module hsv_core_regfile
    import hsv_core_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk_core,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_en,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);

    logic [NUM_REGS-1:0][XLEN-1:0] r_regs;
    logic                          w_wrValid;

    assign w_wrValid = wr_en && (wr_addr != AW'(REG_ZERO));

    // Entry 0 is never written, so it stays at its reset value and folds away in synthesis.
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_wrValid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

`ifdef HSV_REGFILE_BYPASS_EN
    logic w_fwdValid;

    assign w_fwdValid = w_wrValid && !rst;
`endif

    hsv_core_regfile_rdport #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN),
        .AW       (AW)
    ) u_rdport1 (
        .i_regs     (r_regs),
        .i_addr     (rd_addr1),
`ifdef HSV_REGFILE_BYPASS_EN
        .i_fwdValid (w_fwdValid),
        .i_wrAddr   (wr_addr),
        .i_wrData   (wr_data),
`endif
        .o_data     (rd_data1)
    );

    hsv_core_regfile_rdport #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN),
        .AW       (AW)
    ) u_rdport2 (
        .i_regs     (r_regs),
        .i_addr     (rd_addr2),
`ifdef HSV_REGFILE_BYPASS_EN
        .i_fwdValid (w_fwdValid),
        .i_wrAddr   (wr_addr),
        .i_wrData   (wr_data),
`endif
        .o_data     (rd_data2)
    );

endmodule

// File: tb/tb_hsv_core_regfile.sv
// Self-checking bench for hsv_core_regfile: array model checked every negedge plus literal pins.
// Honours HSV_REGFILE_BYPASS_EN when the design is built with forwarding.
module tb_hsv_core_regfile;

    logic        clk_core;
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model [32];

    hsv_core_regfile dut (
        .clk_core (clk_core),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    // Architectural state: cleared whenever reset is high, written at a rising edge otherwise.
    always @(posedge clk_core or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wr_en && wr_addr != 5'd0) begin
            model[wr_addr] = wr_data;
        end
    end

    function automatic logic [31:0] expectedRead(input logic [4:0] addr);
        logic [31:0] value;
        if (addr == 5'd0) return 32'h0;
        value = model[addr];
`ifdef HSV_REGFILE_BYPASS_EN
        if (!rst && wr_en && wr_addr == addr) value = wr_data;
`endif
        return value;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reads are combinational, so both ports are meaningful on every cycle.
    always @(negedge clk_core) begin
        checkOutput($sformatf("port1 x%0d", rd_addr1), rd_data1, expectedRead(rd_addr1));
        checkOutput($sformatf("port2 x%0d", rd_addr2), rd_data2, expectedRead(rd_addr2));
    end

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        @(posedge clk_core);
        #2;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = ra1;
        rd_addr2 = ra2;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        $display("[TB] reset sweep");
        repeat (2) @(posedge clk_core);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), 32'hffff0000 | 32'(a), 5'(a), 5'(31 - a));
            #1;
            checkOutput("reset port1", rd_data1, 32'h0);
            checkOutput("reset port2", rd_data2, 32'h0);
        end
        @(posedge clk_core);
        #2;
        rst   = 1'b0;
        wr_en = 1'b0;

        $display("[TB] basic write/read");
        applyStimulus(1'b1, 5'd3, 32'hdeadbeef, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd15, 32'hcafebabe, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd15);
        #1;
        checkOutput("x3 readback", rd_data1, 32'hdeadbeef);
        checkOutput("x15 readback", rd_data2, 32'hcafebabe);

        $display("[TB] x0 immutability");
        applyStimulus(1'b1, 5'd0, 32'hffffffff, 5'd1, 5'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        checkOutput("x0 after write", rd_data1, 32'h0);

        $display("[TB] write enable");
        applyStimulus(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd3);
        applyStimulus(1'b1, 5'd3, 32'h00000001, 5'd7, 5'd15);
        #1;
        checkOutput("x7 untouched", rd_data1, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd15);
        #1;
        checkOutput("x3 overwrite", rd_data1, 32'h00000001);
        checkOutput("x15 unchanged", rd_data2, 32'hcafebabe);

        $display("[TB] same-cycle read/write");
        applyStimulus(1'b1, 5'd5, 32'haaaa5555, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd5, 32'h5555aaaa, 5'd5, 5'd5);
        #1;
`ifdef HSV_REGFILE_BYPASS_EN
        checkOutput("x5 before edge", rd_data1, 32'h5555aaaa);
`else
        checkOutput("x5 before edge", rd_data1, 32'haaaa5555);
`endif
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        #1;
        checkOutput("x5 after edge", rd_data1, 32'h5555aaaa);

        $display("[TB] back-to-back writes");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h01010101 * 32'(i) ^ 32'h80000000, 5'(i - 1), 5'(32 - i));
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'(i), 32'hbad0bad0, 5'(i), 5'(31 - i));
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd10, 5'd31);
        #1;
        checkOutput("x10 pinned", rd_data1, 32'h8a0a0a0a);
        checkOutput("x31 pinned", rd_data2, 32'h9f1f1f1f);

        $display("[TB] mixed traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("[TB] asynchronous reset");
        applyStimulus(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd10);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
        #1;
        checkOutput("x9 loaded", rd_data1, 32'h99999999);
        rst = 1'b1;
        #1;
        checkOutput("async clear port1", rd_data1, 32'h0);
        checkOutput("async clear port2", rd_data2, 32'h0);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h77777777;
        @(posedge clk_core);
        #2;
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        checkOutput("write during reset", rd_data1, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
        #1;
        checkOutput("x9 after reset", rd_data1, 32'h0);
        checkOutput("x3 after reset", rd_data2, 32'h0);

        @(posedge clk_core);
        @(negedge clk_core);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
